// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_ADD     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic                          overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// One BCD digit of the add-3 correction applied before each shift.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Digits of 5 or more would exceed 9 after doubling; pre-add 3.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(ADJ_THRESH))
      digit_out = digit_in + BCD_DIGIT_W'(ADJ_ADD);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
)(
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BIN_W-1:0]   shift_bin;
  logic [ACC_W-1:0]   bcd_acc;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;

  logic               busy_r;
  logic               done_r;
  logic [ACC_W-1:0]   bcd_r;
  logic               ovf_r;

  logic [ACC_W-1:0]   adj_acc;
  logic [ACC_W-1:0]   next_acc;
  logic [BIN_W-1:0]   next_bin;
  logic               shift_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (bcd_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adj_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next value of {bcd_acc, shift_bin} after one adjust-and-shift step.
  always_comb begin
    next_acc  = {adj_acc[ACC_W-2:0], shift_bin[BIN_W-1]};
    next_bin  = {shift_bin[BIN_W-2:0], 1'b0};
    shift_out = adj_acc[ACC_W-1];
  end

  // Control FSM with registered handshake and result outputs.
  // The result registers load on the final shift edge so that bcd_out and
  // overflow are already valid during the cycle done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_bin <= '0;
      bcd_acc   <= '0;
      ovf_acc   <= 1'b0;
      cnt       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            shift_bin <= bus.bin_in;
            bcd_acc   <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
            busy_r    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_acc   <= next_acc;
          shift_bin <= next_bin;
          ovf_acc   <= ovf_acc | shift_out;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            bcd_r  <= next_acc;
            ovf_r  <= ovf_acc | shift_out;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.overflow = ovf_r;

endmodule
